pipe_hazard_ctrl: RTL and testbench

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It tracks in-flight register writers in a shadow scoreboard, one entry per post-decode stage. From that it drives PC/IF-ID/ID-EX write-enable and flush controls, plus registered forwarding selects for the EX operand muxes. It generalises the fixed stall-only decode hazard logic to configurable depth, optional forwarding, a configurable load-ready point and write-back bypass, and adds saturating stall/redirect performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline.
// A shadow scoreboard follows every instruction leaving ID through the
// NSTAGE post-decode stages (0 = EX ... NSTAGE-1 = WB). Each ID source is
// compared against it to decide between stalling, forwarding or reading
// the register file. Stall and redirect events feed saturating counters.
module pipe_hazard_ctrl #(
  parameter int NSTAGE     = 3,
  parameter int FWD_EN     = 1,
  parameter int LOAD_READY = 1,
  parameter int WB_BYPASS  = 0,
  parameter int CNT_W      = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            id_valid,
  input  logic [4:0]                      id_rs1,
  input  logic [4:0]                      id_rs2,
  input  logic                            id_rs1_used,
  input  logic                            id_rs2_used,
  input  logic [4:0]                      id_rd,
  input  logic                            id_wen,
  input  logic                            id_is_load,
  input  logic                            ex_redirect,
  input  logic                            cnt_clr,
  output logic                            pc_we,
  output logic                            ifid_we,
  output logic                            ifid_flush,
  output logic                            idex_flush,
  output logic [$clog2(NSTAGE+1)-1:0]     fwd_rs1_sel,
  output logic [$clog2(NSTAGE+1)-1:0]     fwd_rs2_sel,
  output logic [CNT_W-1:0]                stall_cnt,
  output logic [CNT_W-1:0]                redirect_cnt
);

  localparam int SW = $clog2(NSTAGE + 1);

  // Scoreboard: one entry per post-decode stage, index 0 is youngest (EX).
  logic [NSTAGE-1:0] sb_valid;
  logic [NSTAGE-1:0] sb_wen;
  logic [NSTAGE-1:0] sb_load;
  logic [4:0]        sb_rd [NSTAGE];

  // Both ID sources are handled by identical logic, indexed 0 = rs1, 1 = rs2.
  logic [4:0]    src      [2];
  logic [1:0]    src_used;
  logic [1:0]    src_haz;
  logic [SW-1:0] next_sel [2];

  logic stall;
  logic advance;

  assign src[0]      = id_rs1;
  assign src[1]      = id_rs2;
  assign src_used[0] = id_rs1_used;
  assign src_used[1] = id_rs2_used;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      // Find the youngest matching writer and classify it as stall/forward/none.
      always_comb begin
        logic hit;
        logic hit_load;
        int   hit_k;
        hit      = 1'b0;
        hit_load = 1'b0;
        hit_k    = 0;
        // Scan oldest to youngest so the lowest matching index wins.
        for (int k = NSTAGE - 1; k >= 0; k--) begin
          if (src_used[gi] && sb_valid[k] && sb_wen[k] &&
              (sb_rd[k] != 5'd0) && (sb_rd[k] == src[gi])) begin
            hit      = 1'b1;
            hit_load = sb_load[k];
            hit_k    = k;
          end
        end
        src_haz[gi]  = 1'b0;
        next_sel[gi] = '0;
        if (hit) begin
          if (FWD_EN == 0) begin
            // Without forwarding only a write-first WB stage avoids a stall.
            src_haz[gi] = (hit_k < NSTAGE - 1) || (WB_BYPASS == 0);
          end else if (hit_load && (hit_k < LOAD_READY)) begin
            src_haz[gi] = 1'b1;
          end else if (hit_k == NSTAGE - 1) begin
            // WB result comes from the register file, not a forward path.
            src_haz[gi] = (WB_BYPASS == 0);
          end else begin
            // Producer will have moved one stage further when we reach EX.
            next_sel[gi] = SW'(hit_k + 1);
          end
        end
      end
    end
  endgenerate

  assign stall   = id_valid && (src_haz != 2'b00);
  assign advance = id_valid && !stall && !ex_redirect;

  // Pipeline control: redirect overrides stall, stall freezes PC and IF/ID.
  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (ex_redirect) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Shift the scoreboard; a bubble enters whenever ID does not advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_valid <= '0;
      sb_wen   <= '0;
      sb_load  <= '0;
      for (int i = 0; i < NSTAGE; i++) sb_rd[i] <= 5'd0;
    end else begin
      sb_valid[0] <= advance;
      sb_wen[0]   <= id_wen;
      sb_load[0]  <= id_is_load;
      sb_rd[0]    <= id_rd;
      for (int i = 1; i < NSTAGE; i++) begin
        sb_valid[i] <= sb_valid[i-1];
        sb_wen[i]   <= sb_wen[i-1];
        sb_load[i]  <= sb_load[i-1];
        sb_rd[i]    <= sb_rd[i-1];
      end
    end
  end

  // Forward selects follow the instruction into EX; bubbles read the RF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_rs1_sel <= '0;
      fwd_rs2_sel <= '0;
    end else if (advance) begin
      fwd_rs1_sel <= next_sel[0];
      fwd_rs2_sel <= next_sel[1];
    end else begin
      fwd_rs1_sel <= '0;
      fwd_rs2_sel <= '0;
    end
  end

  // Saturating event counters; clear wins over a same-cycle event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (stall && !ex_redirect && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (ex_redirect && (redirect_cnt != {CNT_W{1'b1}}))
        redirect_cnt <= redirect_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Four instances share one stimulus
// stream: u0 defaults, u1 write-first WB, u2 stall-only, u3 stall-only with
// write-first WB and 4-bit counters. Each scenario starts from reset and
// checks only the instances it is about.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic id_valid, id_rs1_used, id_rs2_used, id_wen, id_is_load;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_redirect, cnt_clr;

  logic        pc_we_o [4];
  logic        ifid_we_o [4];
  logic        ifid_flush_o [4];
  logic        idex_flush_o [4];
  logic [1:0]  sel1_o [4];
  logic [1:0]  sel2_o [4];
  logic [31:0] scnt_o [3];
  logic [31:0] rcnt_o [3];
  logic [3:0]  scnt3, rcnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
    .pc_we(pc_we_o[0]), .ifid_we(ifid_we_o[0]), .ifid_flush(ifid_flush_o[0]),
    .idex_flush(idex_flush_o[0]), .fwd_rs1_sel(sel1_o[0]), .fwd_rs2_sel(sel2_o[0]),
    .stall_cnt(scnt_o[0]), .redirect_cnt(rcnt_o[0]));

  pipe_hazard_ctrl #(.WB_BYPASS(1)) u1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
    .pc_we(pc_we_o[1]), .ifid_we(ifid_we_o[1]), .ifid_flush(ifid_flush_o[1]),
    .idex_flush(idex_flush_o[1]), .fwd_rs1_sel(sel1_o[1]), .fwd_rs2_sel(sel2_o[1]),
    .stall_cnt(scnt_o[1]), .redirect_cnt(rcnt_o[1]));

  pipe_hazard_ctrl #(.FWD_EN(0)) u2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
    .pc_we(pc_we_o[2]), .ifid_we(ifid_we_o[2]), .ifid_flush(ifid_flush_o[2]),
    .idex_flush(idex_flush_o[2]), .fwd_rs1_sel(sel1_o[2]), .fwd_rs2_sel(sel2_o[2]),
    .stall_cnt(scnt_o[2]), .redirect_cnt(rcnt_o[2]));

  pipe_hazard_ctrl #(.FWD_EN(0), .WB_BYPASS(1), .CNT_W(4)) u3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
    .pc_we(pc_we_o[3]), .ifid_we(ifid_we_o[3]), .ifid_flush(ifid_flush_o[3]),
    .idex_flush(idex_flush_o[3]), .fwd_rs1_sel(sel1_o[3]), .fwd_rs2_sel(sel2_o[3]),
    .stall_cnt(scnt3), .redirect_cnt(rcnt3));

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One ID transaction: drive after the falling edge, settle, then log it.
  task automatic cyc(input bit v, input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                     input bit u2, input logic [4:0] rd, input bit wen, input bit ld,
                     input bit redir = 1'b0, input bit clr = 1'b0);
    @(negedge clk);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_rd = rd; id_wen = wen; id_is_load = ld; ex_redirect = redir; cnt_clr = clr;
    #1;
    $display("t=%0t id v=%0d rs1=%0d/%0d rs2=%0d/%0d rd=%0d wen=%0d ld=%0d redir=%0d clr=%0d pc_we=%0d%0d%0d%0d",
             $time, v, r1, u1, r2, u2, rd, wen, ld, redir, clr,
             pc_we_o[0], pc_we_o[1], pc_we_o[2], pc_we_o[3]);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_wen = 1'b0;
    id_is_load = 1'b0; ex_redirect = 1'b0; cnt_clr = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_wen = 1'b0;
    id_is_load = 1'b0; ex_redirect = 1'b0; cnt_clr = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    #12;
    check("rst_pc_we", pc_we_o[0], 1);
    check("rst_ifid_we", ifid_we_o[0], 1);
    check("rst_ifid_flush", ifid_flush_o[0], 0);
    check("rst_idex_flush", idex_flush_o[0], 0);
    check("rst_sel1", sel1_o[0], 0);
    check("rst_scnt", scnt_o[0], 0);
    check("rst_rcnt", rcnt_o[0], 0);

    // ALU forwarding: add x5 then two dependents.
    do_reset();
    cyc(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 5, 1, 0, 0, 7, 1, 0);
    check("alu_no_stall", pc_we_o[0], 1);
    check("alu_no_bubble", idex_flush_o[0], 0);
    cyc(1, 0, 0, 5, 1, 8, 1, 0);
    check("alu_sel1_ex", sel1_o[0], 1);
    check("alu_no_stall2", pc_we_o[0], 1);
    idle();
    check("alu_sel2_mem", sel2_o[0], 2);
    check("alu_sel1_clear", sel1_o[0], 0);

    // Load-use: one bubble, then forward from MEM.
    do_reset();
    cyc(1, 0, 0, 0, 0, 6, 1, 1);
    cyc(1, 0, 0, 6, 1, 9, 1, 0);
    check("lu_pc_we", pc_we_o[0], 0);
    check("lu_ifid_we", ifid_we_o[0], 0);
    check("lu_idex_flush", idex_flush_o[0], 1);
    check("lu_ifid_flush", ifid_flush_o[0], 0);
    cyc(1, 0, 0, 6, 1, 9, 1, 0);
    check("lu_scnt", scnt_o[0], 1);
    check("lu_release", pc_we_o[0], 1);
    idle();
    check("lu_sel2", sel2_o[0], 2);

    // Producer in WB while consumer in ID.
    do_reset();
    cyc(1, 0, 0, 0, 0, 10, 1, 0);
    idle();
    idle();
    cyc(1, 10, 1, 0, 0, 0, 0, 0);
    check("wb_stall", pc_we_o[0], 0);
    check("wb_bypass_go", pc_we_o[1], 1);
    cyc(1, 10, 1, 0, 0, 0, 0, 0);
    check("wb_release", pc_we_o[0], 1);
    check("wb_scnt", scnt_o[0], 1);
    check("wb_bypass_scnt", scnt_o[1], 0);
    check("wb_bypass_sel", sel1_o[1], 0);
    idle();
    check("wb_sel_after", sel1_o[0], 0);

    // x0 never creates a dependency.
    do_reset();
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0, 0, 0);
    check("x0_fwd_go", pc_we_o[0], 1);
    check("x0_nofwd_go", pc_we_o[2], 1);
    idle();
    check("x0_sel1", sel1_o[0], 0);
    check("x0_sel2", sel2_o[0], 0);

    // Redirect during a load-use stall.
    do_reset();
    cyc(1, 0, 0, 0, 0, 6, 1, 1);
    cyc(1, 0, 0, 6, 1, 9, 1, 0, 1'b1);
    check("rd_pc_we", pc_we_o[0], 1);
    check("rd_ifid_we", ifid_we_o[0], 1);
    check("rd_ifid_flush", ifid_flush_o[0], 1);
    check("rd_idex_flush", idex_flush_o[0], 1);
    idle();
    check("rd_rcnt", rcnt_o[0], 1);
    check("rd_scnt", scnt_o[0], 0);
    check("rd_sel2", sel2_o[0], 0);

    // Stall-only: 3 bubbles, 2 with write-first WB.
    do_reset();
    cyc(1, 0, 0, 0, 0, 5, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 5, 1, 0, 0, 0, 0, 0);
      check($sformatf("nf_pc_we_%0d", i), pc_we_o[2], (i < 3) ? 0 : 1);
      check($sformatf("nfb_pc_we_%0d", i), pc_we_o[3], (i < 2) ? 0 : 1);
    end
    idle();
    check("nf_scnt", scnt_o[2], 3);
    check("nfb_scnt", scnt3, 2);

    // 20 stalls on a 4-bit counter saturate at 15.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      cyc(1, 0, 0, 0, 0, 5, 1, 0);
      for (int j = 0; j < 3; j++) cyc(1, 5, 1, 0, 0, 0, 0, 0);
    end
    idle();
    check("sat_scnt4", scnt3, 15);
    check("sat_scnt32", scnt_o[2], 30);

    // Clear wins over a same-cycle stall.
    cyc(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    check("clr_stalling", pc_we_o[3], 0);
    idle();
    check("clr_scnt4", scnt3, 0);
    check("clr_scnt32", scnt_o[2], 0);

    // Asynchronous reset in the middle of a stall.
    do_reset();
    cyc(1, 0, 0, 0, 0, 5, 1, 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 0, 0, 0);
    check("mr_stalling", pc_we_o[2], 0);
    check("mr_scnt_pre", scnt_o[2], 1);
    #2;
    reset = 1'b1;
    #1;
    check("mr_pc_we", pc_we_o[2], 1);
    check("mr_ifid_we", ifid_we_o[2], 1);
    check("mr_idex_flush", idex_flush_o[2], 0);
    check("mr_scnt", scnt_o[2], 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_after_go", pc_we_o[2], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
